// File: rtl/ber_sweep_scheduler.sv
// ber_sweep_scheduler
// Runs a BER/SNR sweep: selects the sigma index, paces frames from the block
// generator into the decoder one at a time, accumulates hard-decision bit
// errors against the all-zero codeword and emits one result packet per SNR point.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | after reset, waiting for start
// S_ISSUE  | gen_ready high, waiting for the generator to hand over a frame
// S_DECODE | frame in the decoder, watchdog running
// S_ACCUM  | fold the frame's error count into the point accumulator
// S_REPORT | result packet offered to the FIFO, held until accepted
// S_DONE   | sweep finished, waiting for a new start

module ber_sweep_scheduler #(
  parameter int N                   = 204,
  parameter int SNR_PACKET_SIZE     = 4,
  parameter int ERR_CNT_PACKET_SIZE = 28,
  parameter int SNR_FIRST           = 0,
  parameter int SNR_LAST            = 10,
  parameter int MAX_FRAMES          = 100000,
  parameter int TARGET_ERR          = 1000,
  parameter int TIMEOUT_CYCLES      = 4095
) (
  input  logic                                          sys_clk,
  input  logic                                          rstn,
  input  logic                                          start,
  input  logic                                          gen_valid,
  output logic                                          gen_ready,
  input  logic                                          decode_termination,
  input  logic [N-1:0]                                  hard_decision,
  output logic [SNR_PACKET_SIZE-1:0]                    snr_sel,
  output logic [ERR_CNT_PACKET_SIZE+SNR_PACKET_SIZE-1:0] res_data,
  output logic                                          res_valid,
  input  logic                                          res_ready,
  output logic [19:0]                                   frame_cnt,
  output logic [7:0]                                    timeout_cnt,
  output logic                                          sweep_busy,
  output logic                                          sweep_done
);

  localparam int AW = ERR_CNT_PACKET_SIZE;
  localparam int SW = SNR_PACKET_SIZE;

  localparam logic [SW-1:0] SNR_FIRST_V  = SW'(SNR_FIRST);
  localparam logic [SW-1:0] SNR_LAST_V   = SW'(SNR_LAST);
  localparam logic [19:0]   MAX_FRAMES_V = 20'(MAX_FRAMES);
  localparam logic [AW-1:0] TARGET_V     = AW'(TARGET_ERR);
  localparam logic [AW-1:0] ACC_MAX      = '1;
  // Down-counter load: expiry lands on the TIMEOUT_CYCLES-th DECODE cycle.
  localparam logic [11:0]   WD_LOAD      = 12'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    N_V          = 8'(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DECODE,
    S_ACCUM,
    S_REPORT,
    S_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] err_acc;
  logic [7:0]    err_frame;
  logic [11:0]   wd_cnt;
  logic [7:0]    popcnt;
  logic [AW:0]   acc_sum;
  logic [AW-1:0] acc_next;
  logic [19:0]   frame_next;
  logic          point_done;

  // Number of ones in the decoder's hard decisions (bit errors vs all-zero).
  always_comb begin
    popcnt = '0;
    for (int i = 0; i < N; i++) begin
      popcnt = popcnt + 8'(hard_decision[i]);
    end
  end

  // Saturating accumulate and end-of-point decision used in S_ACCUM.
  always_comb begin
    acc_sum    = {1'b0, err_acc} + (AW+1)'(err_frame);
    acc_next   = acc_sum[AW] ? ACC_MAX : acc_sum[AW-1:0];
    frame_next = frame_cnt + 20'd1;
    point_done = (frame_next == MAX_FRAMES_V) || (acc_next >= TARGET_V);
  end

  // Sweep sequencer with registered outputs.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      snr_sel     <= SNR_FIRST_V;
      gen_ready   <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      frame_cnt   <= '0;
      timeout_cnt <= '0;
      sweep_busy  <= 1'b0;
      sweep_done  <= 1'b0;
      err_acc     <= '0;
      err_frame   <= '0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_ISSUE;
            snr_sel     <= SNR_FIRST_V;
            err_acc     <= '0;
            frame_cnt   <= '0;
            timeout_cnt <= '0;
            gen_ready   <= 1'b1;
            sweep_busy  <= 1'b1;
            sweep_done  <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (gen_valid && gen_ready) begin
            state     <= S_DECODE;
            gen_ready <= 1'b0;
            wd_cnt    <= WD_LOAD;
          end
        end
        S_DECODE: begin
          // A termination in the expiry cycle still counts as a real decode.
          if (decode_termination) begin
            err_frame <= popcnt;
            state     <= S_ACCUM;
          end else if (wd_cnt == 12'd0) begin
            err_frame <= N_V;
            if (timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
            state <= S_ACCUM;
          end else begin
            wd_cnt <= wd_cnt - 12'd1;
          end
        end
        S_ACCUM: begin
          err_acc   <= acc_next;
          frame_cnt <= frame_next;
          if (point_done) begin
            state     <= S_REPORT;
            res_data  <= {acc_next, snr_sel};
            res_valid <= 1'b1;
          end else begin
            state     <= S_ISSUE;
            gen_ready <= 1'b1;
          end
        end
        S_REPORT: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            if (snr_sel == SNR_LAST_V) begin
              state      <= S_DONE;
              sweep_busy <= 1'b0;
              sweep_done <= 1'b1;
            end else begin
              snr_sel   <= snr_sel + SW'(1);
              err_acc   <= '0;
              frame_cnt <= '0;
              state     <= S_ISSUE;
              gen_ready <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ber_sweep_scheduler.md
# ber_sweep_scheduler

Sequencer that runs a complete BER/SNR sweep on the hardware test harness. For each SNR index it drives the sigma-select input of the received-block generator and paces frames into the decoder one at a time. It counts bit errors in the decoder's hard decisions against the all-zero codeword and emits one 32-bit result packet per SNR point. It sits between `receivedBlock_generator`, `entire_decoder_tb` and the result FIFO feeding the PS logger.

## Interface
Parameters:
- N, 204: block length; width of `hard_decision`.
- SNR_PACKET_SIZE, 4: width of the SNR index.
- ERR_CNT_PACKET_SIZE, 28: width of the error accumulator; `res_data` = ERR_CNT_PACKET_SIZE + SNR_PACKET_SIZE = 32 bits.
- SNR_FIRST, 0: first SNR index of the sweep.
- SNR_LAST, 10: last SNR index, inclusive; must be ≥ SNR_FIRST.
- MAX_FRAMES, 100000: frames per SNR point, upper bound; 20-bit frame counter.
- TARGET_ERR, 1000: stop the point early once accumulated errors ≥ this value.
- TIMEOUT_CYCLES, 4095: decode watchdog limit; 12-bit counter.

Ports:
- sys_clk  in  1  single clock for the block.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse; starts a sweep from IDLE or DONE.
- gen_valid  in  1  generator `tvalid_master`.
- gen_ready  out  1  generator `ready_slave`.
- decode_termination  in  1  one-cycle pulse; decoder finished the current frame.
- hard_decision  in  N  decoder hard decisions; valid in the `decode_termination` cycle.
- snr_sel  out  SNR_PACKET_SIZE  index into the sigma table.
- res_data  out  32  {err_acc, snr_sel}.
- res_valid  out  1  result packet valid.
- res_ready  in  1  result FIFO accepts.
- frame_cnt  out  20  frames completed at the current SNR.
- timeout_cnt  out  8  saturating count of watchdog expiries in the sweep.
- sweep_busy  out  1  high in all states except IDLE and DONE.
- sweep_done  out  1  high in DONE.

## Operation
- FSM states: IDLE, ISSUE, DECODE, ACCUM, REPORT, DONE. All outputs are registered.
- IDLE / DONE
  - `start`=1 goes to ISSUE.
  - Entering ISSUE from IDLE/DONE sets `snr_sel`=SNR_FIRST and clears `err_acc`, `frame_cnt` and `timeout_cnt`.
  - `start` is ignored in every other state.
- ISSUE
  - `gen_ready`=1.
  - On a cycle with `gen_valid`&`gen_ready`, the frame is accepted: go to DECODE, drop `gen_ready`, clear the watchdog.
- DECODE
  - `gen_ready`=0; the watchdog increments every cycle.
  - On `decode_termination`: register err_frame = popcount(`hard_decision`) (8 bits, max 204), then go to ACCUM.
  - If the watchdog reaches TIMEOUT_CYCLES first: err_frame = N, `timeout_cnt` increments (saturating at 255), then go to ACCUM.
  - If both happen in the same cycle, `decode_termination` wins.
- ACCUM (one cycle)
  - `err_acc` = min(`err_acc` + err_frame, 2^28−1).
  - `frame_cnt` increments.
  - If the new `frame_cnt` = MAX_FRAMES or the new `err_acc` ≥ TARGET_ERR, go to REPORT; otherwise go to ISSUE.
- REPORT
  - `res_data` = {`err_acc`, `snr_sel`}, `res_valid`=1, held stable until `res_ready`.
  - On `res_valid`&`res_ready`:
    - If `snr_sel` = SNR_LAST, go to DONE.
    - Otherwise `snr_sel` increments, `err_acc` and `frame_cnt` are cleared, and the FSM goes to ISSUE.
- `decode_termination` is ignored outside DECODE; `gen_valid` is ignored outside ISSUE.
- Reset values (async): state IDLE, `snr_sel`=SNR_FIRST, `gen_ready`=0, `res_valid`=0, `res_data`=0, `frame_cnt`=0, `timeout_cnt`=0, `sweep_busy`=0, `sweep_done`=0.
- Reset mid-sweep aborts immediately; no partial packet is emitted.

## Timing
- `start` sampled at edge t: ISSUE at t+1, `gen_ready`=1 at t+1.
- Handshake at edge h: `gen_ready`=0 from h+1.
- `decode_termination` at edge d: ACCUM at d+1; next ISSUE or REPORT at d+2.
- Accepted frame to next `gen_ready`: decode latency + 2 cycles.
- REPORT handshake at edge r: ISSUE with the new `snr_sel` at r+1. `snr_sel` changes only at report acceptance, so it is stable for the whole SNR point.
- `res_valid` is asserted the cycle after ACCUM and stays asserted indefinitely under backpressure.

## Test plan
- SNR_FIRST=0, SNR_LAST=1, MAX_FRAMES=3; 3 errors per frame → two packets: 0x0000_0090 (snr 0) and 0x0000_0091 (snr 1), then `sweep_done`=1.
- TARGET_ERR=10, 6 errors per frame → REPORT after frame 2 with `err_acc`=12 and `frame_cnt`=2.
- Withhold `decode_termination`, TIMEOUT_CYCLES=20 → ACCUM after 20 DECODE cycles, err_frame=204, `timeout_cnt`=1.
- Hold `res_ready`=0 for 50 cycles in REPORT → `res_valid` and `res_data` stable, `gen_ready`=0 throughout; accepted on the cycle `res_ready` rises.
- Pulse `decode_termination` during ISSUE, and `start` during DECODE → both ignored; counters unchanged.
- Assert `rstn`=0 mid-DECODE at snr 3 → all outputs at reset values; a new `start` restarts from `snr_sel`=SNR_FIRST with `err_acc`=0.
